// File: rtl/parking_occupancy_ctrl.sv
// Car-park occupancy controller: arbitrates entry/exit gate handshakes and
// sequences an external 4-bit adder/subtractor to update the occupancy count.
module parking_occupancy_ctrl #(
  parameter int unsigned CAPACITY = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       denied,
  output logic       as_s,
  output logic [3:0] as_a,
  output logic [3:0] as_b,
  input  logic [4:0] as_sum,
  output logic [3:0] count,
  output logic       full,
  output logic       empty
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
  typedef enum logic {SIDE_ENTRY, SIDE_EXIT} side_t;

  state_t        state, state_n;
  side_t         last_grant, last_grant_n;
  side_t         grant, grant_n;
  side_t         sel;
  logic          legal;
  logic          granted_req;
  logic [CW-1:0] count_n, as_a_n, as_b_n;
  logic          entry_ack_n, exit_ack_n, denied_n, as_s_n;

  // Status decodes of the occupancy register.
  assign full  = (count == CW'(CAPACITY));
  assign empty = (count == '0);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= SIDE_EXIT;
      grant      <= SIDE_ENTRY;
      count      <= '0;
      entry_ack  <= 1'b0;
      exit_ack   <= 1'b0;
      denied     <= 1'b0;
      as_s       <= 1'b0;
      as_a       <= '0;
      as_b       <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      count      <= count_n;
      entry_ack  <= entry_ack_n;
      exit_ack   <= exit_ack_n;
      denied     <= denied_n;
      as_s       <= as_s_n;
      as_a       <= as_a_n;
      as_b       <= as_b_n;
    end
  end

  // Arbitration, adder sequencing and handshake next-state logic.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_n      = grant;
    count_n      = count;
    entry_ack_n  = entry_ack;
    exit_ack_n   = exit_ack;
    denied_n     = denied;
    as_s_n       = as_s;
    as_a_n       = as_a;
    as_b_n       = as_b;
    sel          = SIDE_ENTRY;
    legal        = 1'b0;
    granted_req  = (grant == SIDE_EXIT) ? exit_req : entry_req;

    unique case (state)
      IDLE: begin
        if (entry_req || exit_req) begin
          // Round-robin only matters on a tie; a lone request always wins.
          if (entry_req && exit_req) begin
            sel          = (last_grant == SIDE_EXIT) ? SIDE_ENTRY : SIDE_EXIT;
            last_grant_n = sel;
          end else begin
            sel = exit_req ? SIDE_EXIT : SIDE_ENTRY;
          end
          grant_n = sel;
          legal   = (sel == SIDE_ENTRY) ? (count < CW'(CAPACITY)) : (count != '0);
          if (legal) begin
            as_s_n  = (sel == SIDE_EXIT);
            as_a_n  = count;
            as_b_n  = CW'(1);
            state_n = OP;
          end else begin
            entry_ack_n = (sel == SIDE_ENTRY);
            exit_ack_n  = (sel == SIDE_EXIT);
            denied_n    = 1'b1;
            state_n     = DONE;
          end
        end
      end
      OP: begin
        // A missing carry on subtract would mean a wrap below zero.
        if (as_s && !as_sum[4]) begin
          denied_n = 1'b1;
        end else begin
          count_n  = as_sum[3:0];
          denied_n = 1'b0;
        end
        entry_ack_n = (grant == SIDE_ENTRY);
        exit_ack_n  = (grant == SIDE_EXIT);
        state_n     = DONE;
      end
      DONE: begin
        if (!granted_req) begin
          entry_ack_n = 1'b0;
          exit_ack_n  = 1'b0;
          denied_n    = 1'b0;
          as_b_n      = '0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Self-checking bench for parking_occupancy_ctrl: vector table, directed
// corner sequences and random traffic against an occupancy model.
module tb_parking_occupancy_ctrl;

  localparam int CAP = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       entry_req, exit_req;
  logic       entry_ack, exit_ack, denied;
  logic       as_s;
  logic [3:0] as_a, as_b, count;
  logic [4:0] as_sum;
  logic       full, empty;
  logic       sum_ovr;
  logic [4:0] sum_ovr_val;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: occupancy and which side won the last tie.
  int m_count;
  bit m_last_exit;

  typedef struct {
    bit side;        // 1 = exit
    int exp_count;
    bit exp_denied;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  // External combinational adder/subtractor.
  assign as_sum = sum_ovr ? sum_ovr_val :
                  (as_s ? ({1'b0, as_a} + {1'b0, ~as_b} + 5'd1)
                        : ({1'b0, as_a} + {1'b0, as_b}));

  parking_occupancy_ctrl #(.CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .entry_req(entry_req), .exit_req(exit_req),
    .entry_ack(entry_ack), .exit_ack(exit_ack), .denied(denied),
    .as_s(as_s), .as_a(as_a), .as_b(as_b), .as_sum(as_sum),
    .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic ack_of(input bit side);
    return side ? exit_ack : entry_ack;
  endfunction

  function automatic bit is_legal(input bit side);
    return side ? (m_count > 0) : (m_count < CAP);
  endfunction

  task automatic chk_status();
    chk("count", int'(count), m_count);
    chk("full", int'(full), int'(m_count == CAP));
    chk("empty", int'(empty), int'(m_count == 0));
  endtask

  // Req for 'side' is already high (or raised here); wait for ack, check, release.
  task automatic wait_ack(input bit side, input bit legal, input bit uf, output bit got_den);
    int cyc = 0;
    if (side) exit_req = 1'b1; else entry_req = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && legal) begin
        chk("as_s", int'(as_s), int'(side));
        chk("as_a", int'(as_a), m_count);
        chk("as_b", int'(as_b), 1);
        chk("early_ack", int'(ack_of(side)), 0);
      end
    end while (ack_of(side) !== 1'b1 && cyc < 8);
    chk("ack_latency", cyc, legal ? 2 : 1);
    chk("other_ack", int'(ack_of(!side)), 0);
    chk("denied", int'(denied), int'(!legal || uf));
    if (!legal) chk("as_b_idle", int'(as_b), 0);
    got_den = denied;
    if (legal && !uf) m_count = side ? m_count - 1 : m_count + 1;
    chk_status();
    if (side) exit_req = 1'b0; else entry_req = 1'b0;
    @(negedge clk);
    chk("ack_release", int'(ack_of(side)), 0);
    chk("denied_release", int'(denied), 0);
  endtask

  task automatic service(input bit side);
    bit d;
    wait_ack(side, is_legal(side), 1'b0, d);
  endtask

  // Both requests rise together; model picks the round-robin winner.
  task automatic tie();
    bit first, d;
    first = m_last_exit ? 1'b0 : 1'b1;
    m_last_exit = first;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    wait_ack(first, is_legal(first), 1'b0, d);
    wait_ack(!first, is_legal(!first), 1'b0, d);
  endtask

  initial begin
    bit d;
    entry_req = 1'b0; exit_req = 1'b0;
    sum_ovr = 1'b0; sum_ovr_val = '0;
    m_count = 0; m_last_exit = 1'b1;
    rst_n = 1'b0;

    // Reset values.
    #12;
    chk("rst_entry_ack", int'(entry_ack), 0);
    chk("rst_exit_ack", int'(exit_ack), 0);
    chk("rst_denied", int'(denied), 0);
    chk("rst_as_s", int'(as_s), 0);
    chk("rst_as_a", int'(as_a), 0);
    chk("rst_as_b", int'(as_b), 0);
    chk_status();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table from empty: denied exit, fill to capacity, denied entry, turnover.
    vecs[0] = '{1'b1, 0, 1'b1};
    for (int i = 1; i <= 12; i++) vecs[i] = '{1'b0, i, 1'b0};
    vecs[13] = '{1'b0, 12, 1'b1};
    vecs[14] = '{1'b1, 11, 1'b0};
    vecs[15] = '{1'b0, 12, 1'b0};
    vecs[16] = '{1'b0, 12, 1'b1};
    for (int i = 0; i < 17; i++) begin
      wait_ack(vecs[i].side, is_legal(vecs[i].side), 1'b0, d);
      chk("vec_denied", int'(d), int'(vecs[i].exp_denied));
      chk("vec_count", int'(count), vecs[i].exp_count);
    end

    // Down to 5, then two ties: entry first, then exit first.
    for (int i = 0; i < 7; i++) service(1'b1);
    chk("count_at_5", int'(count), 5);
    tie();
    chk("tie1_count", int'(count), 5);
    tie();
    chk("tie2_count", int'(count), 5);

    // Exit from 3 gives 2 through the real subtract result 5'b10010.
    service(1'b1); service(1'b1);
    chk("count_at_3", int'(count), 3);
    service(1'b1);
    chk("count_at_2", int'(count), 2);

    // Adder reporting a borrow on subtract: denied, count held.
    sum_ovr = 1'b1; sum_ovr_val = 5'b00001;
    wait_ack(1'b1, 1'b1, 1'b1, d);
    sum_ovr = 1'b0;
    chk("uf_count", int'(count), 2);

    // Reset during OP discards the update; held req is serviced afterwards.
    for (int i = 0; i < 5; i++) service(1'b0);
    chk("count_at_7", int'(count), 7);
    entry_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_count = 0; m_last_exit = 1'b1;
    chk("mid_rst_ack", int'(entry_ack), 0);
    chk("mid_rst_as_b", int'(as_b), 0);
    chk_status();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b0, 1'b1, 1'b0, d);
    chk("post_rst_count", int'(count), 1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: service(1'b0);
        1: service(1'b1);
        2: tie();
        default: repeat ($urandom_range(1, 3)) @(negedge clk);
      endcase
    end
    chk_status();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
